// File: rtl/soc_system_pb_debounce.sv
// Push-button conditioner: per-pin synchroniser, counter debounce, clean level bus
// for the pb PIO and single-cycle press/release pulses.
module soc_system_pb_debounce #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_db,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic             any_change
);

  localparam int unsigned      CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [WIDTH-1:0] IDLE      = ACTIVE_LOW ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  localparam logic             PRESS_LVL = ~ACTIVE_LOW;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_t;

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] w_sample;

  state_t           r_state     [WIDTH];
  state_t           w_state_nxt [WIDTH];
  logic [CNT_W-1:0] r_cnt       [WIDTH];
  logic [CNT_W-1:0] w_cnt_nxt   [WIDTH];

  logic [WIDTH-1:0] w_db_nxt;
  logic [WIDTH-1:0] w_press_nxt;
  logic [WIDTH-1:0] w_release_nxt;
  logic             w_any_nxt;

  // Plain flop chain per pin; the last stage is the sampled value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= IDLE;
      end
    end else begin
      r_sync[0] <= btn_raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_sample = r_sync[SYNC_STAGES-1];

  // Per-channel state, counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_state[i] <= ST_STABLE;
        r_cnt[i]   <= '0;
      end
      btn_db        <= IDLE;
      press_pulse   <= '0;
      release_pulse <= '0;
      any_change    <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      btn_db        <= w_db_nxt;
      press_pulse   <= w_press_nxt;
      release_pulse <= w_release_nxt;
      any_change    <= w_any_nxt;
    end
  end

  // Next-state: the edge that would bring the count to DEBOUNCE_CYCLES accepts,
  // so the counter saturates there instead of wrapping.
  always_comb begin
    w_db_nxt      = btn_db;
    w_press_nxt   = '0;
    w_release_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        ST_STABLE: begin
          w_cnt_nxt[i] = '0;
          if (w_sample[i] != btn_db[i]) begin
            w_state_nxt[i] = ST_COUNTING;
            w_cnt_nxt[i]   = CNT_W'(1);
          end
        end
        ST_COUNTING: begin
          if (w_sample[i] == btn_db[i]) begin
            w_state_nxt[i] = ST_STABLE;
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] == CNT_LAST) begin
            w_state_nxt[i] = ST_STABLE;
            w_cnt_nxt[i]   = '0;
            w_db_nxt[i]    = w_sample[i];
            if (w_sample[i] == PRESS_LVL) begin
              w_press_nxt[i] = 1'b1;
            end else begin
              w_release_nxt[i] = 1'b1;
            end
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt[i] = ST_STABLE;
          w_cnt_nxt[i]   = '0;
        end
      endcase
    end
    w_any_nxt = |(w_press_nxt | w_release_nxt);
  end

endmodule
